// File: rtl/start_done_pkg.sv
// Shared types for the target side of the start/done handshake.
package start_done_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} sd_state_t;

    localparam int DONE_LEVEL      = 0;
    localparam int DONE_PULSE_MODE = 1;

endpackage

// File: rtl/start_edge_det.sv
// Optional synchronizer chain on the start input plus rise/fall detection
// on the synchronized level.
module start_edge_det #(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic lvl_q;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign lvl = d;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // NOTE: reset sits in the sensitivity list so it acts between clock edges.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= d;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign lvl = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // NOTE: non-blocking assignments for every flop so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q <= 1'b0;
        end else begin
            lvl_q <= lvl;
        end
    end

    assign rise = lvl & ~lvl_q;
    assign fall = ~lvl & lvl_q;

endmodule

// File: rtl/start_done_responder.sv
// Target-side responder: qualifies the start pulse width, runs a fixed-length
// job from the start fall, then signals done. Misuse raises sticky flags.
module start_done_responder
    import start_done_pkg::*;
#(
    parameter int WORK_CYCLES = 4,
    parameter int CNT_W       = 16,
    parameter int START_MIN   = 2,
    parameter int SYNC_STAGES = 0,
    parameter int DONE_PULSE  = DONE_LEVEL
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done,
    output logic busy,
    output logic err_short,
    output logic err_overrun
);

    localparam int                HCNT_W     = (START_MIN < 2) ? 1 : $clog2(START_MIN + 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX   = HCNT_W'(START_MIN);
    localparam logic [CNT_W-1:0]  WCNT_INIT  = CNT_W'(WORK_CYCLES - 1);
    localparam bit                PULSE_MODE = (DONE_PULSE == DONE_PULSE_MODE);

    generate
        if (WORK_CYCLES < 1 || longint'(WORK_CYCLES) >= (longint'(1) << CNT_W) || SYNC_STAGES > 2)
        begin : g_bad_params
            $error("start_done_responder: illegal WORK_CYCLES/CNT_W/SYNC_STAGES combination");
        end
    endgenerate

    sd_state_t         state, state_next;
    logic [HCNT_W-1:0] hcnt, hcnt_next;
    logic [CNT_W-1:0]  wcnt, wcnt_next;
    logic              set_short, set_overrun;
    logic              done_next, busy_next;
    logic              lvl, rise, fall;

    start_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk (clk),
        .rst (rst),
        .d   (start),
        .lvl (lvl),
        .rise(rise),
        .fall(fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hcnt        <= '0;
            wcnt        <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            err_short   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state <= state_next;
            hcnt  <= hcnt_next;
            wcnt  <= wcnt_next;
            done  <= done_next;
            busy  <= busy_next;
            if (set_short)   err_short   <= 1'b1;
            if (set_overrun) err_overrun <= 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_next  = state;
        hcnt_next   = hcnt;
        wcnt_next   = wcnt;
        set_short   = 1'b0;
        set_overrun = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = ARMED;
                    hcnt_next  = HCNT_W'(1);
                end
            end
            ARMED: begin
                if (fall) begin
                    if (hcnt >= HCNT_MAX) begin
                        state_next = RUN;
                        wcnt_next  = WCNT_INIT;
                    end else begin
                        state_next = IDLE;
                        set_short  = 1'b1;
                    end
                end else if (lvl && hcnt < HCNT_MAX) begin
                    hcnt_next = hcnt + HCNT_W'(1);
                end
            end
            RUN: begin
                // A rise here never restarts the job, even on the completion edge.
                if (rise) set_overrun = 1'b1;
                if (wcnt == '0) begin
                    state_next = DONE;
                end else begin
                    wcnt_next = wcnt - CNT_W'(1);
                end
            end
            DONE: begin
                if (PULSE_MODE) begin
                    state_next = IDLE;
                    if (rise) set_overrun = 1'b1;
                end else if (rise) begin
                    state_next = ARMED;
                    hcnt_next  = HCNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        done_next = (state_next == DONE);
        busy_next = (state_next == ARMED) || (state_next == RUN);
    end

endmodule
